// File: rtl/gpr_rr_arbiter.sv
// Round-robin access controller for a shared 4-entry general-purpose register file.
// One single-beat read or write is granted per cycle; the response is registered and tagged with the owner.
module gpr_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ-1:0]      i_we,
  input  logic [2*NREQ-1:0]    i_addr,
  input  logic [DW*NREQ-1:0]   i_wdata,
  output logic [NREQ-1:0]      o_gnt,
  output logic                 o_rsp_vld,
  output logic [IW-1:0]        o_rsp_id,
  output logic [DW-1:0]        o_rsp_data,
  output logic [IW-1:0]        o_ptr
);

  logic [DW-1:0]   gpr_q [4];
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   ptr_d;
  logic            rsp_vld_q;
  logic [IW-1:0]   rsp_id_q;
  logic [DW-1:0]   rsp_data_q;

  logic            gnt_vld_s;
  logic [IW-1:0]   gnt_idx_s;
  logic [NREQ-1:0] gnt_s;
  logic            sel_we_s;
  logic [1:0]      sel_addr_s;
  logic [DW-1:0]   sel_wdata_s;
  int              k_v;
  logic [IW-1:0]   k_idx_s;

  // Priority search starting at ptr and wrapping; the grant is held off during reset
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_idx_s = '0;
    gnt_s     = '0;
    k_v       = 0;
    k_idx_s   = '0;
    for (int i = 0; i < NREQ; i++) begin
      k_v = int'(ptr_q) + i;
      if (k_v >= NREQ) begin
        k_v = k_v - NREQ;
      end else begin
        k_v = k_v;
      end
      k_idx_s = IW'(k_v);
      if (i_rst_n && !gnt_vld_s && i_req[k_idx_s]) begin
        gnt_vld_s = 1'b1;
        gnt_idx_s = k_idx_s;
      end else begin
        gnt_vld_s = gnt_vld_s;
      end
    end
    if (gnt_vld_s) begin
      gnt_s[gnt_idx_s] = 1'b1;
    end else begin
      gnt_s = '0;
    end
  end

  // Select the winning requester's access fields and compute the next pointer
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = 2'd0;
    sel_wdata_s = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (gnt_s[j]) begin
        sel_we_s    = i_we[j];
        sel_addr_s  = i_addr[2*j +: 2];
        sel_wdata_s = i_wdata[DW*j +: DW];
      end else begin
        sel_we_s = sel_we_s;
      end
    end
    if (!gnt_vld_s) begin
      ptr_d = ptr_q;
    end else if (gnt_idx_s == IW'(NREQ - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = gnt_idx_s + IW'(1);
    end
  end

  // Register file, pointer and response stage; reads see the pre-edge contents
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      gpr_q[0]   <= DW'(1);
      gpr_q[1]   <= DW'(2);
      gpr_q[2]   <= DW'(3);
      gpr_q[3]   <= DW'(4);
      ptr_q      <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      rsp_vld_q <= gnt_vld_s;
      if (gnt_vld_s) begin
        rsp_id_q <= gnt_idx_s;
        if (sel_we_s) begin
          gpr_q[sel_addr_s] <= sel_wdata_s;
          rsp_data_q        <= sel_wdata_s;
        end else begin
          rsp_data_q <= gpr_q[sel_addr_s];
        end
      end else begin
        rsp_id_q <= rsp_id_q;
      end
    end
  end

  assign o_gnt      = gnt_s;
  assign o_rsp_vld  = rsp_vld_q;
  assign o_rsp_id   = rsp_id_q;
  assign o_rsp_data = rsp_data_q;
  assign o_ptr      = ptr_q;

endmodule

// File: doc/gpr_rr_arbiter.md
# gpr_rr_arbiter

Round-robin arbiter that shares one 4-entry x 32-bit general-purpose register file between NREQ requesters. Each requester issues single-beat read or write accesses. The block grants at most one access per cycle, performs it on the internal register file, and returns a registered response tagged with the requester index. It is the access controller for the GPR datapath in the lab designs.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 32, data width
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_req  in  NREQ  per-requester access request; held until granted
- i_we  in  NREQ  per-requester access type: 1 = write, 0 = read
- i_addr  in  2*NREQ  per-requester register index; requester k uses bits [2k+1:2k]
- i_wdata  in  DW*NREQ  per-requester write data; requester k uses slice k
- o_gnt  out  NREQ  one-hot grant, combinational from i_req and the priority pointer
- o_rsp_vld  out  1  response valid, one-cycle pulse
- o_rsp_id  out  $clog2(NREQ)  index of the requester that owns the response
- o_rsp_data  out  DW  read data; on a write, the data written
- o_ptr  out  $clog2(NREQ)  current highest-priority requester (debug)

## Operation
- Register file: gpr[0..3]. Reset values are 1, 2, 3, 4. No other reset path exists.
- Priority pointer ptr, reset to 0.
  - Search order: ptr, ptr+1, ..., wrapping mod NREQ.
  - The first requester k with i_req[k]=1 gets o_gnt[k]=1. All other grant bits are 0.
- o_gnt is 0 when i_req is 0.
- Handshake: the access is committed on the rising edge where i_req[k] & o_gnt[k].
  - The requester may drop or change i_req[k] after that edge.
  - i_we, i_addr and i_wdata for requester k are sampled only on that edge.
- On commit:
  - Write: gpr[i_addr_k] <= i_wdata_k.
  - Read: captures gpr[i_addr_k] as it was before the edge.
  - ptr <= (k+1) mod NREQ. This wrap applies when k = NREQ-1.
- If no request is present, ptr is held.
- Response stage (registered):
  - o_rsp_vld <= 1, o_rsp_id <= k.
  - o_rsp_data <= read value (for a read) or i_wdata_k (for a write).
  - With no commit, o_rsp_vld <= 0. o_rsp_id and o_rsp_data hold their last values.
- The response has no back-pressure. Requesters must accept o_rsp_vld whenever it is asserted.
- Requests from ungranted requesters are not lost. They stay pending, because the requester holds i_req.
- Fairness: a continuously asserting requester is granted within NREQ cycles.

## Timing
- Grant latency: 0 cycles (combinational) from i_req to o_gnt.
- Access commit: at the edge ending the grant cycle.
- Response: o_rsp_vld is high during the cycle after commit. Read-to-data latency is 1 cycle.
- Throughput: 1 access per cycle, back-to-back, including accesses from the same requester.
- Write followed by read of the same index on the next cycle returns the new value. No hazard bubble is needed.
- Reset (i_rst_n=0 at an edge):
  - ptr=0; gpr = {1,2,3,4}; o_rsp_vld=0; o_rsp_id=0; o_rsp_data=0.
  - Any access in flight is discarded; no response is produced for it.
  - o_gnt is forced to 0 while i_rst_n=0.
- The first grant is possible in the first cycle with i_rst_n=1.

## Test plan
- Reset, then requester 0 reads indices 0..3 back-to-back:
  - Responses 1, 2, 3, 4 with id=0.
  - Each response follows its grant by 1 cycle.
  - o_rsp_vld stays high for 4 consecutive cycles.
- All NREQ=4 requesters assert reads simultaneously and hold them:
  - Grants in order 0, 1, 2, 3.
  - ptr sequence 0→1→2→3→0 (wrap).
  - Each requester is served exactly once in 4 cycles.
- Requester 2 writes 32'hDEADBEEF to index 1; requester 3 reads index 1 in the next grant cycle:
  - Write response data = DEADBEEF, id=2.
  - Read response data = DEADBEEF, id=3.
- ptr=2, only requester 1 requests:
  - Requester 1 is granted immediately.
  - ptr becomes 2.
  - Idle cycles after that keep ptr=2 and o_rsp_vld=0.
- Requester 1 holds i_req continuously while requester 0 requests repeatedly:
  - Grants alternate 0, 1, 0, 1.
  - Neither requester waits more than NREQ cycles.
- Write 7 to index 3, then assert i_rst_n=0 for one cycle while a read is granted:
  - No response for that read.
  - After reset, a read of index 3 returns 4 and ptr=0.
